// File: rtl/reg_pipe_stage_chain.sv
// Elastic register chain of DEPTH stages with per-stage valid bits, collapsing bubbles and occupancy count.
// Optional synchronous flush input enabled by defining REG_PIPE_FLUSH_EN.
module reg_pipe_stage_chain #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef REG_PIPE_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int LW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [LW-1:0]    r_level;

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_srcValid;
  logic [WIDTH-1:0] w_srcData [DEPTH];
  logic             w_flush;
  logic             w_inXfer;
  logic             w_outXfer;

`ifdef REG_PIPE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // A stage can load when it is empty or everything ahead of it will move; a running
  // accumulator keeps the chain free of self-referencing vector bits.
  always_comb begin
    logic acc;
    w_rdy        = '0;
    acc          = out_ready;
    w_rdy[DEPTH] = acc;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc      = !r_valid[i] | acc;
      w_rdy[i] = acc;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_src
      if (g == 0) begin : g_first
        assign w_srcValid[g] = in_valid;
        assign w_srcData[g]  = in_data;
      end else begin : g_rest
        assign w_srcValid[g] = r_valid[g-1];
        assign w_srcData[g]  = r_data[g-1];
      end
    end
  endgenerate

  assign in_ready  = w_rdy[0] & !w_flush;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign level     = r_level;
  assign w_inXfer  = in_valid & in_ready;
  assign w_outXfer = out_valid & out_ready;

  // Data registers only load on a valid source so bubbles never toggle the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VAL;
    end else if (w_flush) begin
      r_valid <= '0;
      r_level <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_valid[i] <= w_srcValid[i];
          if (w_srcValid[i]) r_data[i] <= w_srcData[i];
        end
      end
      r_level <= r_level + LW'(w_inXfer) - LW'(w_outXfer);
    end
  end

endmodule

// File: tb/tb_reg_pipe_stage_chain.sv
// Testbench for reg_pipe_stage_chain (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5): vector table,
// directed corner sequences and random traffic against a queue-based word/position model.
module tb_reg_pipe_stage_chain;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RVAL  = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       tbFlush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] level;

  int nChecks = 0;
  int nFails  = 0;

  reg_pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RVAL)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef REG_PIPE_FLUSH_EN
    .flush     (tbFlush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Model: queue of held words (oldest first) each tagged with its stage position.
  logic [7:0] mData[$];
  int         mPos[$];
  int         mNew[$];
  bit         mPop;
  logic [7:0] mLastOut;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mData.delete();
    mPos.delete();
    mLastOut = RVAL;
  endtask

  // A word moves forward unless the word directly ahead of it stays put.
  task automatic modelPlan(input bit orr, input bit fl, output bit irExp);
    int p;
    int np;
    mNew.delete();
    mPop = 0;
    for (int k = 0; k < mPos.size(); k++) begin
      p = mPos[k];
      if (k == 0) begin
        if (p == DEPTH - 1) begin
          if (orr) begin np = DEPTH; mPop = 1; end
          else np = p;
        end else np = p + 1;
      end else begin
        np = (p + 1 < mNew[k-1]) ? p + 1 : p;
      end
      mNew.push_back(np);
    end
    irExp = !fl && !(mNew.size() > 0 && mNew[mNew.size()-1] == 0);
  endtask

  task automatic modelEdge(input bit v, input logic [7:0] d, input bit ir, input bit fl);
    if (fl) begin
      mData.delete();
      mPos.delete();
    end else begin
      for (int k = 0; k < mPos.size(); k++) begin
        mPos[k] = mNew[k];
        if (mNew[k] == DEPTH - 1) mLastOut = mData[k];
      end
      if (mPop) begin
        void'(mData.pop_front());
        void'(mPos.pop_front());
      end
      if (v && ir) begin
        mData.push_back(d);
        mPos.push_back(0);
      end
    end
  endtask

  task automatic checkModelOutputs();
    bit ov;
    ov = (mPos.size() > 0) && (mPos[0] == DEPTH - 1);
    checkOutput("mdl_out_valid", 32'(out_valid), 32'(ov));
    checkOutput("mdl_out_data",  32'(out_data),  32'(mLastOut));
    checkOutput("mdl_level",     32'(level),     32'(mData.size()));
  endtask

  // One clock of stimulus: inputs driven after the falling edge, ready checked before the
  // rising edge, registered outputs checked just after it.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit orr, input bit fl,
                               output bit irAct);
    bit irExp;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = orr;
    tbFlush   = fl;
    #1;
    modelPlan(orr, fl, irExp);
    irAct = in_ready;
    checkOutput("mdl_in_ready", 32'(in_ready), 32'(irExp));
    @(posedge clk);
    modelEdge(v, d, irExp, fl);
    #1;
    checkModelOutputs();
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         orr;
    bit         eIr;
    bit         eOv;
    logic [7:0] eOd;
    int         eLvl;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit ir;
    reset     = 1'b1;
    tbFlush   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    modelReset();

    #7;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'hA5);
    checkOutput("rst_level",     32'(level),     32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Streaming: first word visible after the third edge, then one word per cycle.
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(k <= 8, 8'(k), 1'b1, 1'b0, ir);
      checkOutput("stream_in_ready",  32'(ir),        32'd1);
      checkOutput("stream_out_valid", 32'(out_valid), 32'(k >= 3 && k <= 10));
      if (k >= 3) checkOutput("stream_out_data", 32'(out_data), 32'(k <= 10 ? k - 2 : 8));
      checkOutput("stream_level", 32'(level), 32'(k <= 8 ? (k < 3 ? k : 3) : 11 - k));
    end

    // Backpressure, release, bubble collapse, push+pop while full.
    tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h08, 1};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h08, 2};
    tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h10, 3};
    tbl[3]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h10, 3};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h12, 0};
    tbl[7]  = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'h12, 1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h12, 1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 1};
    tbl[10] = '{1'b1, 8'h21, 1'b0, 1'b1, 1'b1, 8'h20, 2};
    tbl[11] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h20, 3};
    tbl[12] = '{1'b1, 8'h23, 1'b1, 1'b1, 1'b1, 8'h21, 3};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h23, 1};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h23, 0};
    for (int r = 0; r < 16; r++) begin
      applyStimulus(tbl[r].v, tbl[r].d, tbl[r].orr, 1'b0, ir);
      checkOutput($sformatf("tbl%0d_in_ready", r),  32'(ir),        32'(tbl[r].eIr));
      checkOutput($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].eOv));
      checkOutput($sformatf("tbl%0d_out_data", r),  32'(out_data),  32'(tbl[r].eOd));
      checkOutput($sformatf("tbl%0d_level", r),     32'(level),     32'(tbl[r].eLvl));
    end

    // Async reset with two words held and the output word valid.
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b0, ir);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, ir);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, ir);
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, ir);
    checkOutput("pre_rst_level", 32'(level), 32'd2);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h42;
    out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_out_data",  32'(out_data),  32'hA5);
    checkOutput("arst_level",     32'(level),     32'd0);
    checkOutput("arst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    checkOutput("arst_edge_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_edge_level",     32'(level),     32'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    modelReset();

`ifdef REG_PIPE_FLUSH_EN
    // Flush with the chain full, then a fresh word takes DEPTH edges to emerge.
    applyStimulus(1'b1, 8'h50, 1'b0, 1'b0, ir);
    applyStimulus(1'b1, 8'h51, 1'b0, 1'b0, ir);
    applyStimulus(1'b1, 8'h52, 1'b0, 1'b0, ir);
    checkOutput("pre_flush_level", 32'(level), 32'd3);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, ir);
    checkOutput("flush_in_ready",  32'(ir),        32'd0);
    checkOutput("flush_level",     32'(level),     32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'h30, 1'b1, 1'b0, ir);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, ir);
    checkOutput("post_flush_not_yet", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, ir);
    checkOutput("post_flush_out_valid", 32'(out_valid), 32'd1);
    checkOutput("post_flush_out_data",  32'(out_data),  32'h30);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit fl;
      fl = 1'b0;
`ifdef REG_PIPE_FLUSH_EN
      fl = ($urandom_range(0, 29) == 0);
`endif
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, fl, ir);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/reg_pipe_stage_chain.md
Name: reg_pipe_stage_chain

Overview:
- Parametrised successor to the two-stage master/slave register: a chain of DEPTH register stages, each WIDTH bits wide, with per-stage valid bits and valid/ready backpressure.
- Empty stages (bubbles) collapse, so a stalled output does not block upstream stages that still have room.
- Used to retime wide buses across long routes and as a standard elastic pipeline slice between datapath blocks.
- Also reports current occupancy.

Parameters:
- WIDTH, 8: data bits per stage; must be 1 or more.
- DEPTH, 2: number of register stages; must be 1 or more.
- RESET_VAL, 0: WIDTH-bit value loaded into every data register on reset.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset; clears all state immediately, without waiting for a clock edge.
- in_valid, input, 1: upstream presents in_data.
- in_ready, output, 1: chain accepts in_data this cycle.
- in_data, input, WIDTH: input word.
- out_valid, output, 1: last stage holds a valid word.
- out_ready, input, 1: downstream accepts out_data this cycle.
- out_data, output, WIDTH: last stage data register, driven directly from the register.
- level, output, $clog2(DEPTH+1): number of valid stages, 0..DEPTH.

Behaviour:
- State per stage i (0 = input side, DEPTH-1 = output side): v[i] (valid bit) and d[i] (WIDTH-bit data).
- Reset (asynchronous, active-high):
  - all v[i] cleared to 0 and all d[i] set to RESET_VAL.
  - outputs: out_valid=0, out_data=RESET_VAL, level=0, in_ready=1.
  - Reset asserted mid-transfer discards all held words. No transfer occurs on a clock edge while reset is high.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0].
- Stage update on each rising edge where rdy[i]=1:
  - v[i] <= source valid, where source valid is in_valid for i=0 and v[i-1] otherwise.
  - d[i] <= source data, but only when source valid=1. Otherwise d[i] holds its previous value (no toggling on bubbles).
- Stage hold: when rdy[i]=0, v[i] and d[i] hold.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid/out_data stay stable while out_valid=1 and out_ready=0.
- Latency:
  - With out_ready held at 1, a word accepted at edge N appears at out_data/out_valid after edge N+DEPTH-1, i.e. DEPTH edges through the chain.
  - Throughput is 1 word per cycle.
- Full:
  - Full means all v[i]=1 and out_ready=0, so in_ready=0 and input is not accepted.
  - in_ready becomes 1 in the same cycle out_ready rises (combinational pass-through of ready).
  - A simultaneous push and pop while full is allowed; level stays DEPTH.
- Empty: all v=0 gives out_valid=0, level=0, and out_data holds its last value (RESET_VAL after reset).
- Level update, registered:
  - level(next) = level + (input transfer) - (output transfer).
  - No wrap: level never exceeds DEPTH or drops below 0.
- Ordering: words exit in acceptance order; none duplicated or dropped.
- DEPTH=1: a single elastic register. in_ready = !v[0] | out_ready.

Optional Feature:
- Macro: REG_PIPE_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit, synchronous, active-high).
  - On an edge with flush=1, all v[i] clear to 0 and level clears to 0. d[i] hold their values.
  - While flush=1, in_ready=0, so no input transfer occurs.
  - flush is ignored while reset is high; reset takes priority.
- Not defined: the flush port does not exist and behaviour is exactly as above.

Test Plan:
- Reset with WIDTH=8, DEPTH=3, RESET_VAL=8'hA5 -> out_valid=0, out_data=8'hA5, level=0, in_ready=1.
- Streaming: out_ready=1, push 8'h01..8'h08 on consecutive cycles -> 8'h01 visible after the 3rd edge; output 01..08 on consecutive cycles; level steady at 3 during the stream.
- Backpressure:
  - out_ready=0, push 8'h10, 8'h11, 8'h12 -> in_ready=0 after the 3rd push, level=3, out_data=8'h10 held stable.
  - Raise out_ready -> in_ready=1 the same cycle; order 10, 11, 12 preserved.
- Bubble collapse: push 8'h20, idle 2 cycles, push 8'h21 with out_ready=0 -> both held, level=2; the 8'h21 push is accepted while 8'h20 stalls.
- Async reset mid-stream: assert reset between edges with level=2 -> out_valid drops immediately, level=0, out_data=RESET_VAL; no output transfer on the next edge.
- With REG_PIPE_FLUSH_EN, level=3: pulse flush for 1 cycle -> level=0, out_valid=0, in_ready=0 during the pulse; next push 8'h30 emerges after DEPTH edges.
